inventory_restocker: RTL and testbench

INVENTORY_RESTOCKER -- requirements
Module: inventory_restocker

---
 rtl/inventory_restocker_if.sv | 18 +
 rtl/inventory_restocker.sv | 66 ++++++
 tb/tb_inventory_restocker.sv | 95 +++++++++
 3 files changed

// File: rtl/inventory_restocker_if.sv
// inventory_restocker_if: consume/deliver inputs and stock/status outputs of the restocker
interface inventory_restocker_if;
  logic redInventario;
  logic unitDelivered;
  logic reqRestock;
  logic [2:0] stockCount;
  logic endEmptyInventario;
  logic stockFull;
  logic restockFault;
  modport master (
    output redInventario, unitDelivered,
    input reqRestock, stockCount, endEmptyInventario, stockFull, restockFault
  );
  modport slave (
    input redInventario, unitDelivered,
    output reqRestock, stockCount, endEmptyInventario, stockFull, restockFault
  );
endinterface

// File: rtl/inventory_restocker.sv
// inventory_restocker: saturating stock counter with a restock-request FSM and supplier timeout fault
module inventory_restocker #(
  parameter int CAPACITY = 3,
  parameter int LOW_MARK = 1,
  parameter int TIMEOUT  = 15
) (
  input logic clk1,
  input logic reset1,
  inventory_restocker_if.slave bus
);
  localparam logic [2:0] CAP = 3'(CAPACITY);
  localparam logic [2:0] LM  = 3'(LOW_MARK);
  localparam logic [7:0] TO  = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;
  state_t state;
  logic [2:0] count, nc;
  logic [7:0] timer, tinc;
  logic c, d;
  always_comb begin
    c = bus.redInventario;
    d = bus.unitDelivered;
    nc = (c && !d && count != 3'd0) ? count - 3'd1 :
         (d && !c && count != CAP) ? count + 3'd1 : count;
    tinc = timer + {7'd0, timer != 8'hff};
  end
  assign bus.stockCount = count;
  assign bus.endEmptyInventario = count != 3'd0;
  assign bus.stockFull = count == CAP;
  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      state <= IDLE;
      count <= CAP;
      timer <= 8'd0;
      bus.reqRestock <= 1'b0;
      bus.restockFault <= 1'b0;
    end else begin
      count <= nc;
      case (state)
        IDLE: if (nc <= LM) begin
          state <= REQ;
          bus.reqRestock <= 1'b1;
        end
        REQ: if (nc == CAP) begin
          state <= IDLE;
          timer <= 8'd0;
          bus.reqRestock <= 1'b0;
        end else if (d) begin
          timer <= 8'd0;
        end else begin
          timer <= tinc;
          if (tinc == TO) begin
            state <= FAULT;
            bus.restockFault <= 1'b1;
          end
        end
        FAULT: if (d) begin
          state <= (nc == CAP) ? IDLE : REQ;
          bus.reqRestock <= nc != CAP;
          bus.restockFault <= 1'b0;
          timer <= 8'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inventory_restocker.sv
// tb_inventory_restocker: directed vector table plus timeout/fault/async-reset sequences
module tb_inventory_restocker;
  logic clk1 = 1'b0;
  logic reset1 = 1'b0;
  int total = 0;
  int bad = 0;
  inventory_restocker_if bus();
  inventory_restocker dut (.clk1(clk1), .reset1(reset1), .bus(bus.slave));
  always #5 clk1 = ~clk1;
  typedef struct {
    logic c;
    logic d;
    logic [2:0] cnt;
    logic req;
    logic flt;
  } vec_t;
  vec_t v[17];
  task automatic check(input string name, input logic [2:0] ec, input logic er, input logic ef);
    logic [6:0] got, exp;
    got = {bus.stockCount, bus.reqRestock, bus.restockFault, bus.endEmptyInventario, bus.stockFull};
    exp = {ec, er, ef, ec != 3'd0, ec == 3'd3};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got{cnt,req,flt,nonempty,full}=%b want=%b", name, got, exp);
    end
  endtask
  task automatic step(input logic c, input logic d);
    @(negedge clk1);
    bus.redInventario = c;
    bus.unitDelivered = d;
    @(posedge clk1);
    #1;
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    v[2]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
    v[3]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
    v[4]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
    v[5]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
    v[6]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
    v[7]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    v[8]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    v[9]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
    v[10] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    v[11] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
    v[12] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    v[13] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    v[14] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    v[15] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    v[16] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    bus.redInventario = 1'b0;
    bus.unitDelivered = 1'b0;
    #12;
    check("reset", 3'd3, 1'b0, 1'b0);
    @(negedge clk1);
    reset1 = 1'b1;
    step(1'b0, 1'b0);
    check("hold", 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step(v[i].c, v[i].d);
      check($sformatf("vec%0d", i), v[i].cnt, v[i].req, v[i].flt);
    end
    repeat (10) step(1'b0, 1'b0);
    check("wait10", 3'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("both_clears_timer", 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("no_fault_yet%0d", i), 3'd1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    check("timeout", 3'd1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("fault_consume", 3'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("fault_deliver", 3'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("req_consume", 3'd0, 1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    check("before_fault2", 3'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("fault2", 3'd0, 1'b1, 1'b1);
    @(negedge clk1);
    #2 reset1 = 1'b0;
    #1 check("async_reset", 3'd3, 1'b0, 1'b0);
    @(negedge clk1);
    reset1 = 1'b1;
    step(1'b1, 1'b0);
    check("post_reset", 3'd2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
